// File: rtl/div_sequencer.sv
// Sequencer for the shared iterative radix-2 restoring divider (DIV/DIVU/REM/REMU).
// Operands are latched in IDLE, special cases are resolved in SETUP, and the result is held in DONE.
module div_sequencer #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            start,
  input  logic [2:0]      divsel,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      rd_in,
  input  logic            hold,
  input  logic            flush,
  output logic            busy,
  output logic            div_ready,
  output logic [XLEN-1:0] divres,
  output logic [4:0]      res_rd
);

  localparam int unsigned SW = XLEN + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ITER  = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic [1:0]      r_op;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic            r_qneg;
  logic            r_rneg;
  logic [XLEN-1:0] r_divres;
  logic [4:0]      r_res_rd;

  logic            w_signed;
  logic            w_dvd_neg;
  logic            w_dvs_neg;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_abs_dvd;
  logic [XLEN-1:0] w_abs_dvs;
  logic [SW-1:0]   w_shift;
  logic [SW-1:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic            w_unused;

  assign w_unused = divsel[2];

  // SETUP-stage decode: in SETUP r_quo still holds the raw dividend and r_dvs the raw divisor.
  assign w_signed   = ~r_op[0];
  assign w_dvd_neg  = w_signed & r_quo[XLEN-1];
  assign w_dvs_neg  = w_signed & r_dvs[XLEN-1];
  assign w_div_zero = (r_dvs == '0);
  assign w_ovf      = w_signed && (r_quo == {1'b1, {(XLEN-1){1'b0}}}) && (r_dvs == '1);
  assign w_special  = w_div_zero | w_ovf;
  assign w_abs_dvd  = w_dvd_neg ? ((~r_quo) + XLEN'(1)) : r_quo;
  assign w_abs_dvs  = w_dvs_neg ? ((~r_dvs) + XLEN'(1)) : r_dvs;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = r_op[1] ? r_quo : '1;
    end else if (w_ovf) begin
      w_special_res = r_op[1] ? '0 : r_quo;
    end
  end

  // One restoring step: shift {rem,quo} left and subtract with a full XLEN+1 bit width.
  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});

  assign w_quo_fix = r_qneg ? ((~r_quo) + XLEN'(1)) : r_quo;
  assign w_rem_fix = r_rneg ? ((~r_rem) + XLEN'(1)) : r_rem;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else if (!hold) begin
      case (r_state)
        S_IDLE:  if (start) w_next = S_SETUP;
        S_SETUP: w_next = w_special ? S_DONE : S_ITER;
        S_ITER:  if (r_cnt == CNT_W'(1)) w_next = S_FIX;
        S_FIX:   w_next = S_DONE;
        S_DONE:  if (!start) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Datapath registers; frozen by hold, left untouched by flush (the FSM discards the work).
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_op     <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_divres <= '0;
      r_res_rd <= '0;
    end else if (!flush && !hold) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op     <= divsel[1:0];
            r_quo    <= dividend;
            r_dvs    <= divisor;
            r_rem    <= '0;
            r_res_rd <= rd_in;
          end
        end
        S_SETUP: begin
          r_qneg <= w_dvd_neg ^ w_dvs_neg;
          r_rneg <= w_dvd_neg;
          r_quo  <= w_abs_dvd;
          r_dvs  <= w_abs_dvs;
          r_rem  <= '0;
          r_cnt  <= CNT_W'(XLEN);
          if (w_special) begin
            r_divres <= w_special_res;
          end
        end
        S_ITER: begin
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
          r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          r_divres <= r_op[1] ? w_rem_fix : w_quo_fix;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign div_ready = (r_state == S_DONE);
  assign divres    = r_divres;
  assign res_rd    = r_res_rd;

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed vector table, random ops against an arithmetic model,
// and hand-written flush / hold / reset sequences.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        Rst;
  logic        start;
  logic [2:0]  divsel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [4:0]  rd_in;
  logic        hold;
  logic        flush;
  logic        busy;
  logic        div_ready;
  logic [31:0] divres;
  logic [4:0]  res_rd;

  int n_cmp = 0;
  int n_err = 0;

  div_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .Rst(Rst), .start(start), .divsel(divsel),
    .dividend(dividend), .divisor(divisor), .rd_in(rd_in),
    .hold(hold), .flush(flush), .busy(busy), .div_ready(div_ready),
    .divres(divres), .res_rd(res_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RISC-V division semantics from plain arithmetic; latency from the special-case rule.
  function automatic void model(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output int lat);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] m;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; m = a; lat = 2;
    end else if (!sel[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; m = 32'd0; lat = 2;
    end else if (!sel[0]) begin
      q = 32'(sa / sb); m = 32'(sa % sb); lat = 35;
    end else begin
      q = a / b; m = a % b; lat = 35;
    end
    r = sel[1] ? m : q;
  endfunction

  // Runs one request with start held until after ready; optional hold window in edges.
  task automatic do_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int hold_at, input int hold_len,
                       input logic [31:0] exp_res, input int exp_lat, input string tag);
    int lat;
    logic [31:0] res0;
    @(negedge clk);
    start    = 1'b1;
    divsel   = {1'($urandom_range(0, 1)), sel};
    dividend = a;
    divisor  = b;
    rd_in    = rd;
    lat      = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
      if (div_ready) break;
      if (lat == hold_at) hold = 1'b1;
      if (lat == hold_at + hold_len) hold = 1'b0;
      if (lat > 100) break;
    end
    hold = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " divres"}, divres, exp_res);
    check({tag, " res_rd"}, 32'(res_rd), 32'(rd));
    res0 = divres;
    repeat (2) @(posedge clk);
    #1;
    check({tag, " ready_held"}, 32'(div_ready), 32'd1);
    check({tag, " divres_stable"}, divres, res0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, " idle_busy"}, 32'(busy), 32'd0);
    check({tag, " idle_ready"}, 32'(div_ready), 32'd0);
  endtask

  initial begin
    logic [31:0] er;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rs;
    int el;
    int saw_ready;

    Rst = 1'b0; start = 1'b0; divsel = '0; dividend = '0; divisor = '0;
    rd_in = '0; hold = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst ready", 32'(div_ready), 32'd0);
    check("rst divres", divres, 32'd0);
    check("rst res_rd", 32'(res_rd), 32'd0);
    @(negedge clk);
    Rst = 1'b1;

    tbl.push_back(vec_t'{2'd1, 32'd100,        32'd7,          32'd14,         35});
    tbl.push_back(vec_t'{2'd3, 32'd100,        32'd7,          32'd2,          35});
    tbl.push_back(vec_t'{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35});
    tbl.push_back(vec_t'{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35});
    tbl.push_back(vec_t'{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          35});
    tbl.push_back(vec_t'{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  2});
    tbl.push_back(vec_t'{2'd2, 32'd5,          32'd0,          32'd5,          2});
    tbl.push_back(vec_t'{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2});
    tbl.push_back(vec_t'{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2});
    tbl.push_back(vec_t'{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          35});
    tbl.push_back(vec_t'{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  35});
    tbl.push_back(vec_t'{2'd0, 32'h8000_0000,  32'd1,          32'h8000_0000,  35});
    tbl.push_back(vec_t'{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  35});
    tbl.push_back(vec_t'{2'd3, 32'd0,          32'd0,          32'd0,          2});
    tbl.push_back(vec_t'{2'd0, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         35});

    foreach (tbl[i]) begin
      do_op(tbl[i].sel, tbl[i].a, tbl[i].b, 5'(i + 1), 0, 0, tbl[i].exp, tbl[i].lat,
            $sformatf("vec%0d", i));
    end

    for (int k = 0; k < 40; k++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        4: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      model(rs, ra, rb, er, el);
      do_op(rs, ra, rb, 5'($urandom_range(0, 31)), 0, 0, er, el, $sformatf("rnd%0d", k));
    end

    // flush in IDLE blocks acceptance
    @(negedge clk);
    start = 1'b1; flush = 1'b1; divsel = 3'b001; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    #1;
    check("flush_idle busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;

    // flush mid-ITER
    @(negedge clk);
    start = 1'b1; divsel = 3'b001; dividend = 32'd100; divisor = 32'd7; rd_in = 5'd9;
    repeat (12) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; start = 1'b0;
    @(posedge clk);
    #1;
    check("flush busy", 32'(busy), 32'd0);
    check("flush ready", 32'(div_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    saw_ready = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (div_ready) saw_ready = 1;
    end
    check("flush no_ready", 32'(saw_ready), 32'd0);
    do_op(2'd1, 32'd9, 32'd3, 5'd3, 0, 0, 32'd3, 35, "post_flush");

    // hold for 5 edges mid-ITER
    do_op(2'd1, 32'd100, 32'd7, 5'd5, 10, 5, 32'd14, 40, "hold");
    do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd6, 20, 5, 32'hFFFF_FFFD, 40, "hold_signed");

    // async reset mid-ITER
    @(negedge clk);
    start = 1'b1; divsel = 3'b010; dividend = 32'd77; divisor = 32'd5; rd_in = 5'd17;
    repeat (10) @(posedge clk);
    #2;
    Rst = 1'b0;
    #1;
    check("rst_mid busy", 32'(busy), 32'd0);
    check("rst_mid ready", 32'(div_ready), 32'd0);
    check("rst_mid divres", divres, 32'd0);
    check("rst_mid res_rd", 32'(res_rd), 32'd0);
    @(negedge clk);
    start = 1'b0;
    Rst = 1'b1;
    do_op(2'd3, 32'd77, 32'd5, 5'd17, 0, 0, 32'd2, 35, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
